uart_rx_core: RTL and testbench



---
 rtl/uart_rx_core.sv | 152 +++++++++++++++
 tb/tb_uart_rx_core.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 asynchronous serial receiver, LSB first, idle-high line.
// rxd is synchronized into the clock domain; each good byte is presented on
// data with a single-cycle data_ready strobe.
// Optional build macro UART_RX_FRAME_ERR_EN adds a frame_error pulse output
// (bad stop bit or aborted start bit).
module uart_rx_core #(
   parameter int CLKS_PER_BIT = 217,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       rxd,
   output logic [7:0] data,
   output logic       data_ready
`ifdef UART_RX_FRAME_ERR_EN
   ,
   output logic       frame_error
`endif
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

   state_t               state, state_nxt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                 rx_s;
   logic                 rx_prev;
   logic [CNT_W-1:0]     clk_cnt, clk_cnt_nxt;
   logic [2:0]           bit_cnt, bit_cnt_nxt;
   logic [7:0]           shreg, shreg_nxt;
   logic [7:0]           data_nxt;
   logic                 ready_nxt;
`ifdef UART_RX_FRAME_ERR_EN
   logic                 ferr_nxt;
`endif

   assign rx_s = sync_q[SYNC_STAGES-1];

   // rxd synchronizer, preset to the idle level; rx_prev remembers the last
   // synchronized sample so IDLE only starts on a genuine 1->0 transition.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q  <= '1;
         rx_prev <= 1'b1;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], rxd};
         rx_prev <= rx_s;
      end
   end

   // State, timing counters, shift register and output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         clk_cnt    <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         data       <= '0;
         data_ready <= 1'b0;
      end else begin
         state      <= state_nxt;
         clk_cnt    <= clk_cnt_nxt;
         bit_cnt    <= bit_cnt_nxt;
         shreg      <= shreg_nxt;
         data       <= data_nxt;
         data_ready <= ready_nxt;
      end
   end

`ifdef UART_RX_FRAME_ERR_EN
   // Error strobe is registered alongside data_ready so both share timing.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) frame_error <= 1'b0;
      else          frame_error <= ferr_nxt;
   end
`endif

   // Next-state and datapath: sample mid-bit, shift LSB-first from the top.
   always_comb begin
      state_nxt   = state;
      clk_cnt_nxt = clk_cnt;
      bit_cnt_nxt = bit_cnt;
      shreg_nxt   = shreg;
      data_nxt    = data;
      ready_nxt   = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      ferr_nxt    = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (!rx_s && rx_prev) begin
               state_nxt   = START;
               clk_cnt_nxt = '0;
            end
         end
         START: begin
            if (clk_cnt == HALF_M1) begin
               clk_cnt_nxt = '0;
               if (rx_s) begin
                  // Line went back high before mid start bit: a glitch.
                  state_nxt = IDLE;
`ifdef UART_RX_FRAME_ERR_EN
                  ferr_nxt  = 1'b1;
`endif
               end else begin
                  bit_cnt_nxt = '0;
                  state_nxt   = DATA;
               end
            end else begin
               clk_cnt_nxt = clk_cnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (clk_cnt == FULL_M1) begin
               clk_cnt_nxt = '0;
               shreg_nxt   = {rx_s, shreg[7:1]};
               if (bit_cnt == 3'd7) state_nxt   = STOP;
               else                 bit_cnt_nxt = bit_cnt + 3'd1;
            end else begin
               clk_cnt_nxt = clk_cnt + CNT_W'(1);
            end
         end
         STOP: begin
            if (clk_cnt == FULL_M1) begin
               clk_cnt_nxt = '0;
               if (rx_s) begin
                  // Leave at mid stop bit so a following start bit is caught.
                  data_nxt  = shreg;
                  ready_nxt = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = WAIT_IDLE;
`ifdef UART_RX_FRAME_ERR_EN
                  ferr_nxt  = 1'b1;
`endif
               end
            end else begin
               clk_cnt_nxt = clk_cnt + CNT_W'(1);
            end
         end
         WAIT_IDLE: begin
            // Break or stuck-low line: wait for the line to recover.
            if (rx_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: the stimulus process serialises bytes
// onto rxd and queues the bytes a receiver must deliver; a monitor pops the
// queue on every data_ready pulse and checks data and latency.
`timescale 1ns/1ps
module tb_uart_rx_core;
   localparam int  CPB  = 32;
   localparam int  SYNC = 2;
   localparam real BP   = 320.0;                  // nominal bit period, ns
   localparam int  LAT  = (19 * CPB) / 2 + SYNC + 1; // start edge -> pulse

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       rxd = 1'b1;
   logic [7:0] data;
   logic       data_ready;
`ifdef UART_RX_FRAME_ERR_EN
   logic       frame_error;
   int         ferr_cnt = 0;
   int         ferr_exp = 0;
`endif

   typedef struct {
      logic [7:0] b;
      int         c0;
   } exp_t;

   exp_t       sbq[$];
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         pulses = 0;
   logic       prev_rdy = 1'b0;
   logic [7:0] last_good = 8'h00;

   uart_rx_core #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .rxd        (rxd),
      .data       (data),
      .data_ready (data_ready)
`ifdef UART_RX_FRAME_ERR_EN
      ,
      .frame_error(frame_error)
`endif
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic note_ferr();
`ifdef UART_RX_FRAME_ERR_EN
      ferr_exp++;
`endif
   endtask

   // Monitor: every pulse must match the oldest queued byte and arrive at
   // the expected time after that frame's start edge.
   always @(negedge clock) begin
      exp_t e;
      int   lat;
      if (reset_n) begin
         if (data_ready) begin
            pulses++;
            check("ready_single_cycle", {31'd0, prev_rdy}, 32'd0);
            if (sbq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_pulse data=%0h required=no_pulse", data);
            end else begin
               e = sbq.pop_front();
               check("data", {24'd0, data}, {24'd0, e.b});
               lat = cyc - e.c0;
               checks++;
               if (lat < LAT - 2 || lat > LAT + 2) begin
                  failures++;
                  $display("FAIL latency actual=%0d required=%0d+-2", lat, LAT);
               end
            end
         end
`ifdef UART_RX_FRAME_ERR_EN
         if (frame_error) ferr_cnt++;
`endif
      end
      prev_rdy = data_ready;
   end

   task automatic idle_bits(input real n, input real bp);
      rxd = 1'b1;
      #(n * bp);
   endtask

   task automatic send_frame(input logic [7:0] b, input real bp, input logic stop_v);
      exp_t e;
      e.b  = b;
      e.c0 = cyc;
      if (stop_v) begin
         sbq.push_back(e);
         last_good = b;
      end else begin
         note_ferr();
      end
      rxd = 1'b0; #(bp);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i]; #(bp);
      end
      rxd = stop_v; #(bp);
   endtask

   initial begin
      int p0;
      int g;
      real bp;
      logic [7:0] rb;
      logic bad;

      rxd = 1'b1;
      reset_n = 1'b0;
      repeat (5) @(negedge clock);
      check("reset_data", {24'd0, data}, 32'd0);
      check("reset_ready", {31'd0, data_ready}, 32'd0);
`ifdef UART_RX_FRAME_ERR_EN
      check("reset_ferr", {31'd0, frame_error}, 32'd0);
`endif
      reset_n = 1'b1;
      idle_bits(2.0, BP);

      // '@' then 'K' about 40 bit-times later.
      p0 = pulses;
      @(negedge clock); send_frame(8'h40, BP, 1'b1); idle_bits(1.0, BP);
      check("data_40", {24'd0, data}, 32'h40);
      check("pulses_40", pulses - p0, 1);
      idle_bits(39.0, BP);
      p0 = pulses;
      @(negedge clock); send_frame(8'h4B, BP, 1'b1); idle_bits(20.0, BP);
      check("data_4b_hold", {24'd0, data}, 32'h4B);
      check("pulses_4b", pulses - p0, 1);

      // Back-to-back frames, no idle gap.
      p0 = pulses;
      @(negedge clock); send_frame(8'h55, BP, 1'b1); send_frame(8'hAA, BP, 1'b1);
      idle_bits(2.0, BP);
      check("pulses_b2b", pulses - p0, 2);
      check("data_aa", {24'd0, data}, 32'hAA);

      // Short low glitch, then 0x3C.
      p0 = pulses;
      g = $urandom_range(2, CPB / 4 - 1);
      @(negedge clock); rxd = 1'b0;
      repeat (g) @(negedge clock);
      rxd = 1'b1;
      note_ferr();
      idle_bits(2.0, BP);
      check("glitch_no_pulse", pulses - p0, 0);
      check("glitch_data_held", {24'd0, data}, {24'd0, last_good});
      @(negedge clock); send_frame(8'h3C, BP, 1'b1); idle_bits(1.0, BP);
      check("data_3c", {24'd0, data}, 32'h3C);

      // Framing error: stop bit low, line held low, then 0x12.
      p0 = pulses;
      @(negedge clock); send_frame(8'hA5, BP, 1'b0);
      rxd = 1'b0; #(3.0 * BP);
      idle_bits(2.0, BP);
      check("ferr_no_pulse", pulses - p0, 0);
      check("ferr_data_held", {24'd0, data}, 32'h3C);
      @(negedge clock); send_frame(8'h12, BP, 1'b1); idle_bits(1.0, BP);
      check("data_12", {24'd0, data}, 32'h12);
      check("pulses_12", pulses - p0, 1);
`ifdef UART_RX_FRAME_ERR_EN
      check("ferr_count_directed", ferr_cnt, ferr_exp);
`endif

      // Reset in the middle of the data bits of 0xFF, then 0x81.
      @(negedge clock);
      rxd = 1'b0; #(BP);
      rxd = 1'b1; #(4.0 * BP);
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      check("midreset_data", {24'd0, data}, 32'd0);
      check("midreset_ready", {31'd0, data_ready}, 32'd0);
      last_good = 8'h00;
      reset_n = 1'b1;
      p0 = pulses;
      idle_bits(6.0, BP);
      check("postreset_no_pulse", pulses - p0, 0);
      @(negedge clock); send_frame(8'h81, BP, 1'b1); idle_bits(1.0, BP);
      check("data_81", {24'd0, data}, 32'h81);
      check("pulses_81", pulses - p0, 1);

      // Random bytes, baud within +-3%, random gaps, occasional bad stop bit.
      for (int n = 0; n < 30; n++) begin
         rb  = 8'($urandom_range(0, 255));
         bp  = BP * (1.0 + ($itor($urandom_range(0, 60)) - 30.0) / 1000.0);
         bad = ($urandom_range(0, 7) == 0);
         @(negedge clock);
         send_frame(rb, bp, !bad);
         if (bad) begin
            rxd = 1'b0; #(bp);
            idle_bits(1.0, bp);
         end else begin
            idle_bits($itor($urandom_range(0, 2)), bp);
         end
      end
      idle_bits(2.0, BP);

      // Drain: every queued byte must have been delivered.
      for (int w = 0; w < 2000 && sbq.size() != 0; w++) @(negedge clock);
      check("queue_empty", sbq.size(), 0);
      check("data_final", {24'd0, data}, {24'd0, last_good});
`ifdef UART_RX_FRAME_ERR_EN
      check("ferr_count_total", ferr_cnt, ferr_exp);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
